// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: M-stage req/ack sequencer in front of a multi-cycle data RAM.
// Build option MEM_TIMEOUT_EN adds a wait counter that aborts an ACCESS after TIMEOUT cycles.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic        ram_ack,
    input  logic [31:0] ram_rdata,
    output logic [31:0] RD_RAM,
    output logic        StallM,
    output logic        MemErrM
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state, state_nx;
    logic   mem_op;
    logic   launch;
    logic   finish;
    logic   abort;

    if (TIMEOUT < 1 || TIMEOUT > (2 ** CNT_W) - 1) begin : g_bad_timeout
        $error("TIMEOUT must be between 1 and 2**CNT_W-1");
    end

    assign mem_op = MemReadM | MemWriteM;
    assign launch = (state == IDLE) && mem_op;
    assign finish = (state == ACCESS) && (ram_ack || abort);

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;

    // An ack in the last allowed cycle takes priority over the abort.
    assign abort = (state == ACCESS) && !ram_ack && (cnt == CNT_W'(TIMEOUT - 1));

    // Wait counter: cleared while idle, counts every ACCESS cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= (state == ACCESS) ? cnt + 1'b1 : '0;
    end

    // Error flag is raised only for the DONE cycle that follows an abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            MemErrM <= 1'b0;
        else
            MemErrM <= abort;
    end
`else
    assign abort   = 1'b0;
    assign MemErrM = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state and stall: DONE always returns to IDLE so a held strobe cannot relaunch the same op.
    always_comb begin
        state_nx = (state == IDLE)   ? (mem_op ? ACCESS : IDLE) :
                   (state == ACCESS) ? ((ram_ack || abort) ? DONE : ACCESS) : IDLE;
        StallM   = (state == ACCESS) || launch;
    end

    // RAM request side and load result; address/data/we only change at launch so they hold under req.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            RD_RAM    <= '0;
        end else if (launch) begin
            ram_req   <= 1'b1;
            ram_we    <= MemWriteM;
            ram_addr  <= ALUOutM;
            ram_wdata <= WriteDataM;
        end else if (finish) begin
            ram_req   <= 1'b0;
            RD_RAM    <= ram_we ? RD_RAM : (ram_ack ? ram_rdata : 32'h0000_0000);
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and random checks of mem_access_ctrl against a transaction-level model.
module tb_mem_access_ctrl;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM = 1'b0, MemWriteM = 1'b0, ram_ack = 1'b0;
    logic [31:0] ALUOutM = '0, WriteDataM = '0, ram_rdata = '0;
    logic        ram_req, ram_we, StallM, MemErrM;
    logic [31:0] ram_addr, ram_wdata, RD_RAM;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .ram_req(ram_req), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ack(ram_ack), .ram_rdata(ram_rdata),
        .RD_RAM(RD_RAM), .StallM(StallM), .MemErrM(MemErrM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction model: one outstanding request, how many access cycles it has waited,
    // and whether the previous cycle just completed one (the pipeline advances then).
    bit          m_req = 0, m_we = 0, m_err = 0, m_just_done = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rd = '0;
    int          m_waited = 0;

    task automatic model_step();
        if (rst) begin
            m_req = 0; m_we = 0; m_err = 0; m_just_done = 0;
            m_addr = '0; m_wdata = '0; m_rd = '0; m_waited = 0;
            return;
        end
        m_err = 0;
        if (m_req) begin
            m_waited++;
            if (ram_ack) begin
                m_req = 0; m_just_done = 1;
                if (!m_we) m_rd = ram_rdata;
            end
`ifdef MEM_TIMEOUT_EN
            else if (m_waited == TIMEOUT) begin
                m_req = 0; m_just_done = 1; m_err = 1;
                if (!m_we) m_rd = '0;
            end
`endif
        end else if (m_just_done) begin
            m_just_done = 0;
        end else if (MemReadM || MemWriteM) begin
            m_req = 1; m_we = MemWriteM; m_addr = ALUOutM; m_wdata = WriteDataM; m_waited = 0;
        end
    endtask

    // Compare process: advance the model at each edge, check every output shortly after.
    always @(posedge clk) begin
        model_step();
        #1;
        chk("cmp_req", ram_req, m_req);
        chk("cmp_stall", StallM, m_req || (!m_just_done && (MemReadM || MemWriteM)));
        chk("cmp_rd", RD_RAM, m_rd);
        chk("cmp_err", MemErrM, m_err);
        if (m_req) begin
            chk("cmp_we", ram_we, m_we);
            chk("cmp_addr", ram_addr, m_addr);
            chk("cmp_wdata", ram_wdata, m_wdata);
        end
    end

    // Issue one op and ride it to its DONE cycle; returns the number of stalled cycles.
    task automatic do_op(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input int ack_at, output int stalls);
        int n = 0;
        stalls = 0;
        @(negedge clk);
        MemReadM = !wr; MemWriteM = wr; ALUOutM = addr; WriteDataM = data; ram_ack = 0;
        #1;
        while (StallM && n < 40) begin
            stalls++;
            @(negedge clk);
            n++;
            ram_ack   = (n == ack_at);
            ram_rdata = (n == ack_at) ? rdata : $urandom;
            ALUOutM   = $urandom;
            WriteDataM = $urandom;
            #1;
            if (StallM) begin
                chk("op_req_held", ram_req, 1);
                chk("op_we", ram_we, wr);
                chk("op_addr_stable", ram_addr, addr);
                chk("op_wdata_stable", ram_wdata, data);
            end
        end
        if (n >= 40) chk("op_wait_bound", 0, 1);
        MemReadM = 0; MemWriteM = 0; ram_ack = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int stalls, rises;
        logic prev_req;
        logic [5:0] stall_pat;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_req", ram_req, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_rd", RD_RAM, 0);
        chk("rst_err", MemErrM, 0);
        chk("rst_stall", StallM, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(0, 32'h10, 32'h0, 32'h1234_5678, 1, stalls);
        chk("ld_stalls", stalls, 2);
        chk("ld_done_stall", StallM, 0);
        chk("ld_done_req", ram_req, 0);
        chk("ld_rd", RD_RAM, 32'h1234_5678);

        do_op(1, 32'h20, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 4, stalls);
        chk("st_stalls", stalls, 5);
        chk("st_done_stall", StallM, 0);
        chk("st_rd_kept", RD_RAM, 32'h1234_5678);

        rises = 0; prev_req = 0; stall_pat = '0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            MemReadM = (i < 6); ALUOutM = 32'h100 + i; ram_ack = 1; ram_rdata = 32'hB000_0000 + i;
            #1;
            stall_pat[6-i] = StallM;
            if (ram_req && !prev_req) rises++;
            prev_req = ram_req;
        end
        chk("b2b_stall_pattern", 32'(stall_pat), 32'b110110);
        chk("b2b_req_pulses", rises, 2);
        chk("b2b_rd", RD_RAM, 32'hB000_0005);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            MemReadM = 0; MemWriteM = 0; ram_ack = i[0]; ram_rdata = $urandom;
            #1;
            chk("idle_stall", StallM, 0);
            chk("idle_req", ram_req, 0);
            chk("idle_rd", RD_RAM, 32'hB000_0005);
        end

        @(negedge clk);
        MemReadM = 1; ALUOutM = 32'h40; ram_ack = 0;
        @(negedge clk);
        #1;
        chk("mid_rst_req_before", ram_req, 1);
        rst = 1; MemReadM = 0;
        #1;
        chk("mid_rst_req", ram_req, 0);
        chk("mid_rst_rd", RD_RAM, 0);
        chk("mid_rst_stall", StallM, 0);
        @(negedge clk);
        rst = 0; ram_ack = 1; ram_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        #1;
        chk("post_rst_rd", RD_RAM, 0);
        chk("post_rst_req", ram_req, 0);
        ram_ack = 0;

`ifdef MEM_TIMEOUT_EN
        do_op(0, 32'h50, 32'h0, 32'h0000_5A5A, 1, stalls);
        chk("to_pre_rd", RD_RAM, 32'h0000_5A5A);
        do_op(0, 32'h60, 32'h0, 32'h0, 0, stalls);
        chk("to_stalls", stalls, TIMEOUT + 1);
        chk("to_req", ram_req, 0);
        chk("to_err", MemErrM, 1);
        chk("to_rd", RD_RAM, 0);
        @(negedge clk);
        #1;
        chk("to_err_clear", MemErrM, 0);
        do_op(0, 32'h70, 32'h0, 32'h600D_600D, TIMEOUT, stalls);
        chk("to_ack_stalls", stalls, TIMEOUT + 1);
        chk("to_ack_err", MemErrM, 0);
        chk("to_ack_rd", RD_RAM, 32'h600D_600D);
`endif

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 199) == 0);
            MemReadM   = ($urandom_range(0, 9) < 4);
            MemWriteM  = ($urandom_range(0, 9) < 3);
            ALUOutM    = $urandom;
            WriteDataM = $urandom;
            ram_ack    = ($urandom_range(0, 2) == 0);
            ram_rdata  = $urandom;
        end
        @(negedge clk);
        rst = 0; MemReadM = 0; MemWriteM = 0; ram_ack = 0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access sequencer for the 5-stage pipeline. It turns the single-cycle MemReadM/MemWriteM strobes into a req/ack transaction on a multi-cycle data RAM, and holds the pipeline with StallM until the RAM answers. It presents the returned word on RD_RAM to the MEM/WB register. It sits between the M-stage control/ALU outputs and the data RAM; the hazard unit consumes StallM.

## Interface
- TIMEOUT, 16, ACCESS cycles allowed before abort (MEM_TIMEOUT_EN builds only); must be ≤ 2^CNT_W − 1
- CNT_W, 5, width of the wait counter
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-high reset
- MemReadM  input  1  M-stage load strobe
- MemWriteM  input  1  M-stage store strobe
- ALUOutM  input  32  effective address
- WriteDataM  input  32  store data
- ram_req  output  1  registered request to RAM
- ram_we  output  1  registered write enable, valid with ram_req
- ram_addr  output  32  registered address
- ram_wdata  output  32  registered store data
- ram_ack  input  1  RAM completion, sampled only in ACCESS
- ram_rdata  input  32  RAM read data, valid with ram_ack
- RD_RAM  output  32  registered load result to MEM/WB
- StallM  output  1  freeze F..M stages; the hazard unit also forces RegWriteM low into MEM/WB while high
- MemErrM  output  1  timeout abort flag, valid in DONE

## Operation
- States: IDLE, ACCESS, DONE. Encoding is free.
- IDLE:
  - If MemReadM|MemWriteM: StallM=1 (combinational).
  - Next edge: ram_req←1, ram_we←MemWriteM, ram_addr←ALUOutM, ram_wdata←WriteDataM, counter←0, go to ACCESS.
  - No memory op: remain in IDLE, StallM=0.
- MemReadM and MemWriteM both high: treated as a write. RD_RAM is not updated.
- ACCESS:
  - StallM=1; the counter increments every cycle.
  - ram_ack high at an edge: ram_req←0, RD_RAM←ram_rdata (reads only), go to DONE.
- DONE:
  - StallM=0 and ram_req=0. The pipeline advances at this edge; MEM/WB captures RD_RAM.
  - Next state is unconditionally IDLE. This stops the completed instruction from re-launching.
- RD_RAM holds its last value at all other times. Writes never modify it.
- ram_ack outside ACCESS is ignored.
- ram_addr, ram_wdata and ram_we stay stable for the whole time ram_req is high.

## Timing
- Reset (async): state=IDLE. ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, RD_RAM=0, MemErrM=0, counter=0.
- StallM after reset follows the IDLE rule.
- Reset asserted mid-ACCESS abandons the transaction. ram_req drops immediately and no result is captured.
- ram_req rises one cycle after a memory op is first seen in IDLE.
- With ack in the first ACCESS cycle, a memory op holds M for 3 cycles (IDLE, ACCESS, DONE), i.e. 2 stall cycles.
- Each extra ACCESS cycle without ack adds 1 stall cycle.
- Back-to-back memory ops: pattern IDLE→ACCESS→DONE→IDLE→ACCESS… with StallM=0 only in the DONE cycles.

## Configuration
- MEM_TIMEOUT_EN defined:
  - In ACCESS, if the counter reaches TIMEOUT with ram_ack low: ram_req←0, RD_RAM←32'h0000_0000 (reads only), MemErrM←1, go to DONE.
  - MemErrM clears on the next edge.
  - Ack arriving in the same cycle as timeout wins: normal completion, MemErrM=0.
- MEM_TIMEOUT_EN undefined:
  - ACCESS waits for ram_ack indefinitely.
  - MemErrM is tied 0 and no counter logic is built.

## Test plan
- Reset, with rst asserted mid-ACCESS → ram_req=0, RD_RAM=0, state IDLE within the same cycle; no capture when ack arrives later.
- Load addr 0x10, ack on first ACCESS cycle with rdata 0x12345678 → StallM high 2 cycles, ram_we=0, RD_RAM=0x12345678 in DONE, StallM=0 in DONE.
- Store addr 0x20, data 0xA5A5A5A5, ack after 4 ACCESS cycles → ram_we=1, address/data stable for all 4 cycles, 5 stall cycles, RD_RAM unchanged.
- Two consecutive loads with 1-cycle acks → exactly two ram_req pulses; StallM low only in the two DONE cycles; no duplicate request.
- No memory op for 10 cycles, ram_ack toggling → StallM=0, ram_req=0, RD_RAM unchanged.
- MEM_TIMEOUT_EN, TIMEOUT=16, load with no ack → ram_req drops after 16 ACCESS cycles, MemErrM=1 for the DONE cycle only, RD_RAM=0; repeat with ack on cycle 16 → MemErrM=0, data captured.
